// File: rtl/conv_maxpool_if.sv
// Signal bundle between conv_maxpool, the conv engine's output read port and the host.
// The master side is the host/conv engine; the slave side is the pooling block.
interface conv_maxpool_if #(
    parameter int unsigned DSIZE = 256
);
    localparam int unsigned AW = $clog2(DSIZE);

    logic [7:0]    in_width;
    logic [7:0]    in_height;
    logic [7:0]    x_stop;
    logic [7:0]    y_stop;
    logic [3:0]    pool_w;
    logic [3:0]    pool_h;
    logic [3:0]    stride_x;
    logic [3:0]    stride_y;
    logic          relu_en;
    logic [AW-1:0] src_addr;
    logic [31:0]   src_data;
    logic [AW-1:0] po_addr;
    logic [31:0]   po_data;
    logic          start;
    logic          busy;
    logic          done;

    modport master (
        output in_width, in_height, x_stop, y_stop, pool_w, pool_h,
        output stride_x, stride_y, relu_en, src_data, po_addr, start,
        input  src_addr, po_data, busy, done
    );

    modport slave (
        input  in_width, in_height, x_stop, y_stop, pool_w, pool_h,
        input  stride_x, stride_y, relu_en, src_data, po_addr, start,
        output src_addr, po_data, busy, done
    );
endinterface

// File: rtl/conv_maxpool.sv
// Post-conv stage: bursts the int8 feature map into a local buffer, then runs optional
// ReLU plus 2D max-pool into an output memory the host reads a word at a time.
module conv_maxpool #(
    parameter int unsigned DSIZE = 256,
    parameter int unsigned PSIZE = 4
) (
    input logic          clk,
    input logic          rst_n,
    conv_maxpool_if.slave io_bus
);
    localparam int unsigned AW = $clog2(DSIZE);
    localparam int unsigned WW = AW - 2;
    localparam int unsigned KW = (PSIZE > 1) ? $clog2(PSIZE) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StPool} state_e;

    state_e             r_state, w_state_next;
    logic [WW-1:0]      r_word_idx, w_word_idx_next;
    logic [KW-1:0]      r_kx, w_kx_next;
    logic [KW-1:0]      r_ky, w_ky_next;
    logic [7:0]         r_ox, w_ox_next;
    logic [7:0]         r_oy, w_oy_next;
    logic [AW-1:0]      r_oi, w_oi_next;
    logic signed [7:0]  r_max, w_max_next;
    logic               r_done, w_done_next;
    logic               w_ib_we, w_po_we;

    logic [7:0] r_ib [DSIZE];
    logic [7:0] r_po [DSIZE];

    logic [15:0]        w_area, w_nw_last;
    logic               w_word_last, w_kx_last, w_ky_last, w_ox_end, w_oy_end, w_first;
    logic [AW-1:0]      w_pix_addr;
    logic signed [7:0]  w_pix, w_val, w_cur_max;

    assign w_area      = 16'(io_bus.in_width) * 16'(io_bus.in_height);
    assign w_nw_last   = ((w_area + 16'd3) >> 2) - 16'd1;
    assign w_word_last = (16'(r_word_idx) == w_nw_last);
    assign w_kx_last   = (4'(r_kx) == io_bus.pool_w - 4'd1);
    assign w_ky_last   = (4'(r_ky) == io_bus.pool_h - 4'd1);
    // Overshoot-safe: the row ends once the next origin would pass the stop point.
    assign w_ox_end    = ({1'b0, r_ox} + {5'b0, io_bus.stride_x}) > {1'b0, io_bus.x_stop};
    assign w_oy_end    = ({1'b0, r_oy} + {5'b0, io_bus.stride_y}) > {1'b0, io_bus.y_stop};

    assign w_pix_addr = (AW'(r_oy) + AW'(r_ky)) * AW'(io_bus.in_width) + AW'(r_ox) + AW'(r_kx);
    assign w_pix      = $signed(r_ib[w_pix_addr]);
    assign w_val      = (io_bus.relu_en && (w_pix < 0)) ? 8'sd0 : w_pix;
    assign w_first    = (r_kx == '0) && (r_ky == '0);
    assign w_cur_max  = (w_first || (w_val > r_max)) ? w_val : r_max;

    assign io_bus.src_addr = {r_word_idx, 2'b00};
    assign io_bus.busy     = (r_state != StIdle);
    assign io_bus.done     = r_done;
    assign io_bus.po_data  = {r_po[io_bus.po_addr + AW'(3)], r_po[io_bus.po_addr + AW'(2)],
                              r_po[io_bus.po_addr + AW'(1)], r_po[io_bus.po_addr]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_word_idx <= '0;
            r_kx       <= '0;
            r_ky       <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_oi       <= '0;
            r_max      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_word_idx <= w_word_idx_next;
            r_kx       <= w_kx_next;
            r_ky       <= w_ky_next;
            r_ox       <= w_ox_next;
            r_oy       <= w_oy_next;
            r_oi       <= w_oi_next;
            r_max      <= w_max_next;
            r_done     <= w_done_next;
        end
    end

    // Buffers are never cleared; write enables are gated by the reset state.
    always_ff @(posedge clk) begin
        if (w_ib_we) begin
            for (int k = 0; k < 4; k++) begin
                r_ib[{r_word_idx, 2'(k)}] <= io_bus.src_data[8*k +: 8];
            end
        end
        if (w_po_we) begin
            r_po[r_oi] <= w_cur_max;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_word_idx_next = r_word_idx;
        w_kx_next       = r_kx;
        w_ky_next       = r_ky;
        w_ox_next       = r_ox;
        w_oy_next       = r_oy;
        w_oi_next       = r_oi;
        w_max_next      = r_max;
        w_done_next     = 1'b0;
        w_ib_we         = 1'b0;
        w_po_we         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (io_bus.start) begin
                    w_state_next    = StLoad;
                    w_word_idx_next = '0;
                    w_kx_next       = '0;
                    w_ky_next       = '0;
                    w_ox_next       = '0;
                    w_oy_next       = '0;
                    w_oi_next       = '0;
                end
            end
            StLoad: begin
                w_ib_we = 1'b1;
                if (w_word_last) begin
                    w_state_next    = StPool;
                    w_word_idx_next = '0;
                end else begin
                    w_word_idx_next = r_word_idx + WW'(1);
                end
            end
            StPool: begin
                w_max_next = w_cur_max;
                if (!w_kx_last) begin
                    w_kx_next = r_kx + KW'(1);
                end else begin
                    w_kx_next = '0;
                    if (!w_ky_last) begin
                        w_ky_next = r_ky + KW'(1);
                    end else begin
                        w_ky_next = '0;
                        w_po_we   = 1'b1;
                        w_oi_next = r_oi + AW'(1);
                        if (!w_ox_end) begin
                            w_ox_next = r_ox + 8'(io_bus.stride_x);
                        end else begin
                            w_ox_next = '0;
                            if (!w_oy_end) begin
                                w_oy_next = r_oy + 8'(io_bus.stride_y);
                            end else begin
                                w_oy_next    = '0;
                                w_done_next  = 1'b1;
                                w_state_next = StIdle;
                            end
                        end
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end
endmodule

// File: tb/tb_conv_maxpool.sv
// Bench for conv_maxpool: directed operations push expected latency/result into a queue;
// a monitor pops and compares on every done pulse.
module tb_conv_maxpool;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [7:0] src_mem [256];

    typedef struct {
        int          lat;
        logic [31:0] word;
        logic [31:0] mask;
    } exp_t;
    exp_t exp_q[$];

    conv_maxpool_if #(.DSIZE(256)) bus ();

    conv_maxpool #(.DSIZE(256), .PSIZE(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.src_data = {src_mem[bus.src_addr + 8'd3], src_mem[bus.src_addr + 8'd2],
                           src_mem[bus.src_addr + 8'd1], src_mem[bus.src_addr]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cfg(input int w, input int h, input int pw, input int ph, input int sx,
                       input int sy, input int xs, input int ys, input int relu);
        bus.in_width  = 8'(w);
        bus.in_height = 8'(h);
        bus.pool_w    = 4'(pw);
        bus.pool_h    = 4'(ph);
        bus.stride_x  = 4'(sx);
        bus.stride_y  = 4'(sy);
        bus.x_stop    = 8'(xs);
        bus.y_stop    = 8'(ys);
        bus.relu_en   = 1'(relu);
    endtask

    // Negedge index i follows the i-th rising edge after the one that samples start.
    task automatic run_op(input int nw, input int lat, input logic [31:0] word,
                          input logic [31:0] mask, input int extra_at, input int abort_at);
        @(negedge clk);
        bus.start = 1'b1;
        start_cyc = cyc + 1;
        if (abort_at < 0) exp_q.push_back('{lat: lat, word: word, mask: mask});
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            bus.start = (i == extra_at);
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_busy", 32'(bus.busy), 32'd0);
                check("abort_done", 32'(bus.done), 32'd0);
                check("abort_src_addr", 32'(bus.src_addr), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            if (i < lat) check("busy_run", 32'(bus.busy), 32'd1);
            else         check("busy_end", 32'(bus.busy), 32'd0);
            if (i < nw)  check("src_addr", 32'(bus.src_addr), 32'(4 * i));
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("done_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", 32'(cyc - start_cyc), 32'(e.lat));
                    check("busy_at_done", 32'(bus.busy), 32'd0);
                    check("po_word0", bus.po_data & e.mask, e.word);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start   = 1'b0;
        bus.po_addr = 8'd0;
        cfg(4, 4, 2, 2, 2, 2, 2, 2, 0);
        for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_src_addr", 32'(bus.src_addr), 32'd0);
        rst_n = 1'b1;

        // 4x4 ramp, 2x2 pool, stride 2
        for (int i = 0; i < 16; i++) src_mem[i] = 8'(i);
        run_op(4, 20, 32'h0F0D0705, 32'hFFFFFFFF, -1, -1);

        // All -5, without and with ReLU
        for (int i = 0; i < 16; i++) src_mem[i] = 8'hFB;
        run_op(4, 20, 32'hFBFBFBFB, 32'hFFFFFFFF, -1, -1);
        cfg(4, 4, 2, 2, 2, 2, 2, 2, 1);
        run_op(4, 20, 32'h00000000, 32'hFFFFFFFF, -1, -1);

        // 3x3, partial last word, stride 1
        src_mem[0] = 8'd10; src_mem[1] = 8'h80; src_mem[2] = 8'd3;
        src_mem[3] = 8'd7;  src_mem[4] = 8'd1;  src_mem[5] = 8'hFF;
        src_mem[6] = 8'd0;  src_mem[7] = 8'd2;  src_mem[8] = 8'hCE;
        cfg(3, 3, 2, 2, 1, 1, 1, 1, 0);
        run_op(3, 19, 32'h0207030A, 32'hFFFFFFFF, -1, -1);

        // 5x1, 1x1 pool, stride 2: max must seed from data, not zero
        src_mem[0] = 8'h80; src_mem[1] = 8'hF9; src_mem[2] = 8'h80;
        src_mem[3] = 8'hFD; src_mem[4] = 8'hF7;
        cfg(5, 1, 1, 1, 2, 1, 4, 0, 0);
        run_op(2, 5, 32'h00F78080, 32'h00FFFFFF, -1, -1);

        // Ramp again with a stray start during POOL
        for (int i = 0; i < 16; i++) src_mem[i] = 8'(i);
        cfg(4, 4, 2, 2, 2, 2, 2, 2, 0);
        run_op(4, 20, 32'h0F0D0705, 32'hFFFFFFFF, 8, -1);

        // Abort mid-POOL after the first window only, then a clean rerun
        for (int i = 0; i < 16; i++) src_mem[i] = 8'hFB;
        run_op(4, 20, 32'h0, 32'h0, -1, 10);
        check("abort_po_word0", bus.po_data, 32'h0F0D07FB);
        for (int i = 0; i < 16; i++) src_mem[i] = 8'(i);
        run_op(4, 20, 32'h0F0D0705, 32'hFFFFFFFF, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
